dm_block_mover: RTL and testbench

Memory-side initiator that drives the data-memory port (address, write enable, write data, combinational read data) to copy or fill a block of words without processor involvement. It sits beside the pipeline's memory stage and shares the data-memory port with it through an external mux, which selects the mover while BUSY is high. The memory reads combinationally on its address and writes at the rising clock edge when write enable is high.

---
 rtl/dm_block_mover_if.sv | 30 +++
 rtl/dm_block_mover.sv | 103 ++++++++++
 tb/tb_dm_block_mover.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_block_mover_if.sv
// Control, status and data-memory port of the block mover, named from the mover's side.
// The mover connects through the slave modport; the controller and memory connect through the master modport.
interface dm_block_mover_if #(
    parameter int WL   = 32,
    parameter int LENW = 8
);
    logic            i_start;
    logic            i_mode;
    logic [WL-1:0]   i_src;
    logic [WL-1:0]   i_dst;
    logic [LENW-1:0] i_len;
    logic [WL-1:0]   i_pattern;
    logic            o_busy;
    logic            o_done;
    logic [LENW-1:0] o_count;
    logic [WL-1:0]   o_dma;
    logic            o_dmwe;
    logic [WL-1:0]   o_dmwd;
    logic [WL-1:0]   i_dmrd;

    modport slave (
        input  i_start, i_mode, i_src, i_dst, i_len, i_pattern, i_dmrd,
        output o_busy, o_done, o_count, o_dma, o_dmwe, o_dmwd
    );

    modport master (
        output i_start, i_mode, i_src, i_dst, i_len, i_pattern, i_dmrd,
        input  o_busy, o_done, o_count, o_dma, o_dmwe, o_dmwd
    );
endinterface

// File: rtl/dm_block_mover.sv
// Copies (read then write, two cycles per word) or fills (one cycle per word) a block of memory words.
// Busy cycles: copy takes 2*LEN+1, fill takes LEN+1, LEN=0 takes 1. START is ignored while busy.
module dm_block_mover #(
    parameter int WL   = 32,
    parameter int LENW = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dm_block_mover_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_FIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WL-1:0]   r_src;
    logic [WL-1:0]   r_dst;
    logic [WL-1:0]   r_pat;
    logic [WL-1:0]   r_data;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_cnt;

    logic [WL-1:0]   w_idx;
    logic            w_last;
    logic [WL-1:0]   w_dma;
    logic [WL-1:0]   w_dmwd;
    logic            w_dmwe;

    // The word index and the written-word count advance together, so one register serves both.
    assign w_idx  = WL'(r_cnt);
    assign w_last = (r_cnt + LENW'(1)) == r_len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_dma  = '0;
        w_dmwd = '0;
        w_dmwe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_len == '0) w_next = S_FIN;
                    else if (bus.i_mode) w_next = S_FILL;
                    else                 w_next = S_RD;
                end
            end
            S_RD: begin
                w_dma  = r_src + w_idx;
                w_next = S_WR;
            end
            S_WR: begin
                w_dma  = r_dst + w_idx;
                w_dmwe = 1'b1;
                w_dmwd = r_data;
                w_next = w_last ? S_FIN : S_RD;
            end
            S_FILL: begin
                w_dma  = r_dst + w_idx;
                w_dmwe = 1'b1;
                w_dmwd = r_pat;
                w_next = w_last ? S_FIN : S_FILL;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_pat  <= '0;
            r_data <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_src <= bus.i_src;
                        r_dst <= bus.i_dst;
                        r_pat <= bus.i_pattern;
                        r_len <= bus.i_len;
                        r_cnt <= '0;
                    end
                end
                S_RD:         r_data <= bus.i_dmrd;
                S_WR, S_FILL: r_cnt  <= r_cnt + LENW'(1);
                default: ;
            endcase
        end
    end

    assign bus.o_dma   = w_dma;
    assign bus.o_dmwe  = w_dmwe;
    assign bus.o_dmwd  = w_dmwd;
    assign bus.o_busy  = (r_state != S_IDLE);
    assign bus.o_done  = (r_state == S_FIN);
    assign bus.o_count = r_cnt;
endmodule

// File: tb/tb_dm_block_mover.sv
// Directed bench for dm_block_mover with a 64-word memory model (address bits [5:0]) and a write-address log.
// Latency is the number of rising edges from the accepting edge until DONE is seen high.
module tb_dm_block_mover;
    localparam int WL   = 32;
    localparam int LENW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_block_mover_if #(.WL(WL), .LENW(LENW)) bus ();

    dm_block_mover #(.WL(WL), .LENW(LENW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:63];
    logic [31:0] wr_log [$];
    logic        ld_en;
    logic [5:0]  ld_a;
    logic [31:0] ld_d;
    int          wr_cnt;

    assign bus.i_dmrd = mem[bus.o_dma[5:0]];

    always @(posedge clk) begin
        if (bus.o_dmwe) begin
            mem[bus.o_dma[5:0]] <= bus.o_dmwd;
            wr_log.push_back(bus.o_dma);
            wr_cnt <= wr_cnt + 1;
        end else if (ld_en) begin
            mem[ld_a] <= ld_d;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mem_set(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Drives START in an IDLE cycle; returns #1 after the accepting edge with START low again.
    task automatic start_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [7:0] l, input logic [31:0] p);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.o_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.i_start   = 1'b1;
        bus.i_mode    = m;
        bus.i_src     = s;
        bus.i_dst     = d;
        bus.i_len     = l;
        bus.i_pattern = p;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        bus.i_src     = 32'hFFFF_FFF0;
        bus.i_dst     = 32'hFFFF_FFF0;
        bus.i_pattern = 32'h0BAD_0BAD;
        bus.i_len     = 8'd200;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.o_done && cyc < 600) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    initial begin
        int cyc;
        int n_bad;
        int n_busy;
        int n_done;
        int w0;

        ld_en  = 1'b0;
        ld_a   = '0;
        ld_d   = '0;
        wr_cnt = 0;
        rst_n  = 1'b0;
        bus.i_start   = 1'($urandom);
        bus.i_mode    = 1'($urandom);
        bus.i_src     = $urandom;
        bus.i_dst     = $urandom;
        bus.i_len     = 8'($urandom);
        bus.i_pattern = $urandom;
        #3;
        chk("rst_dma",  bus.o_dma, 32'h0);
        chk("rst_dmwd", bus.o_dmwd, 32'h0);
        chk("rst_ctl",  {21'h0, bus.o_busy, bus.o_done, bus.o_dmwe, bus.o_count}, 32'h0);
        #20;
        bus.i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.i_src = $urandom;
            if (bus.o_dmwe || bus.o_busy) n_bad++;
        end
        chk("idle_10", n_bad, 0);

        for (int a = 0; a < 64; a++) mem_set(6'(a), 32'h0);
        mem_set(4, 11); mem_set(5, 22); mem_set(6, 33); mem_set(7, 44);

        // Copy 4 words from 4 to 20
        start_op(1'b0, 4, 20, 4, 0);
        chk("copy_busy", bus.o_busy, 1);
        wait_done(cyc);
        chk("copy_lat", cyc, 8);
        chk("copy_cnt", bus.o_count, 4);
        @(negedge clk);
        chk("copy_m20", mem[20], 11);
        chk("copy_m21", mem[21], 22);
        chk("copy_m22", mem[22], 33);
        chk("copy_m23", mem[23], 44);
        chk("copy_src", {mem[4][7:0], mem[5][7:0], mem[6][7:0], mem[7][7:0]}, 32'h0B16_212C);
        chk("copy_cnt_hold", bus.o_count, 4);

        // Fill 5 words at 40 with guards at 39 and 45
        mem_set(39, 32'h39);
        mem_set(45, 32'h45);
        start_op(1'b1, 0, 40, 5, 32'hDEAD_BEEF);
        wait_done(cyc);
        chk("fill_lat", cyc, 5);
        @(negedge clk);
        for (int a = 40; a < 45; a++) chk($sformatf("fill_m%0d", a), mem[a], 32'hDEAD_BEEF);
        chk("fill_m39", mem[39], 32'h39);
        chk("fill_m45", mem[45], 32'h45);

        // Zero length
        w0 = wr_cnt;
        start_op(1'b0, 4, 50, 0, 0);
        chk("len0_busy", bus.o_busy, 1);
        wait_done(cyc);
        chk("len0_lat", cyc, 0);
        @(posedge clk);
        #1 chk("len0_idle", bus.o_busy, 0);
        chk("len0_nowr", wr_cnt - w0, 0);
        chk("len0_cnt", bus.o_count, 0);

        // Overlapping copy propagates mem[10]
        mem_set(10, 7);
        start_op(1'b0, 10, 11, 3, 0);
        wait_done(cyc);
        chk("ovl_lat", cyc, 6);
        @(negedge clk);
        chk("ovl_m11", mem[11], 7);
        chk("ovl_m12", mem[12], 7);
        chk("ovl_m13", mem[13], 7);

        // Fill across the top of the address space
        wr_log.delete();
        start_op(1'b1, 0, 32'hFFFF_FFFF, 2, 32'h5555_AAAA);
        wait_done(cyc);
        @(negedge clk);
        chk("wrap_n", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("wrap_a0", wr_log[0], 32'hFFFF_FFFF);
            chk("wrap_a1", wr_log[1], 32'h0);
        end
        chk("wrap_m0", mem[0], 32'h5555_AAAA);

        // START pulsed during RD, WR and FIN of a 3-word copy
        mem_set(50, 32'h50);
        start_op(1'b0, 20, 30, 3, 0);
        n_busy = 0;
        n_done = 0;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (n < 7 && bus.o_busy) n_busy++;
            if (n == 7) chk("sb_idle7", bus.o_busy, 0);
            if (n == 8) chk("sb_idle8", bus.o_busy, 0);
            if (bus.o_done) n_done++;
            bus.i_start   = (n == 0 || n == 1 || n == 6);
            bus.i_mode    = 1'b1;
            bus.i_dst     = 50;
            bus.i_len     = 1;
            bus.i_pattern = 32'hFEED_FACE;
        end
        bus.i_start = 1'b0;
        chk("sb_busy", n_busy, 7);
        chk("sb_done", n_done, 1);
        chk("sb_m50", mem[50], 32'h50);
        chk("sb_m32", mem[32], 33);

        // Reset during the write of word 2 of a 6-word fill
        for (int a = 30; a < 36; a++) mem_set(6'(a), 0);
        start_op(1'b1, 0, 30, 6, 32'hCAFE_0001);
        @(posedge clk);
        @(posedge clk);
        #2 chk("mid_we_pre", bus.o_dmwe, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_we", bus.o_dmwe, 0);
        chk("mid_cnt", bus.o_count, 0);
        chk("mid_busy", bus.o_busy, 0);
        chk("mid_dma", bus.o_dma, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_m30", mem[30], 32'hCAFE_0001);
        chk("mid_m31", mem[31], 32'hCAFE_0001);
        chk("mid_m32", mem[32], 0);
        chk("mid_m33", mem[33], 0);
        chk("mid_cnt_after", bus.o_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
